// File: rtl/deflate_bit_packer.sv
// Serialises MSB-first variable-length codewords into a left-aligned bit
// accumulator and drains it as bytes; a flush zero-pads the final partial byte.
module deflate_bit_packer #(
  parameter int ACC_W   = 32,
  parameter int MAX_LEN = 18
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [MAX_LEN-1:0] code_in,
  input  logic [5:0]         code_len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               flush_done,
  output logic               len_err
);

  localparam int               CNT_W    = $clog2(ACC_W + 1);
  localparam logic [CNT_W-1:0] CNT_BYTE = CNT_W'(8);
  localparam logic [CNT_W-1:0] CNT_ROOM = CNT_W'(ACC_W - MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ACC_W);

  typedef enum logic {RUN, FLUSH} state_e;

  state_e             state_q;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               flush_done_q;
  logic               len_err_q, len_err_d;

  logic               xfer, accept, len_bad, len_zero;
  logic [CNT_W-1:0]   cnt_post, len_c, shamt;
  logic [MAX_LEN-1:0] code_mask;
  logic [ACC_W-1:0]   code_ext;

  // Every output is decoded from registers only, so no input reaches an output.
  assign in_ready   = (state_q == RUN) && (cnt_q <= CNT_ROOM);
  assign out_valid  = (cnt_q >= CNT_BYTE) || ((state_q == FLUSH) && (cnt_q != '0));
  assign out_data   = acc_q[ACC_W-1 -: 8];
  assign out_last   = (state_q == FLUSH) && (cnt_q != '0) && (cnt_q <= CNT_BYTE);
  assign flush_done = flush_done_q;
  assign len_err    = len_err_q;

  assign xfer      = out_valid && out_ready;
  assign accept    = in_valid && in_ready;
  assign len_bad   = code_len > 6'(MAX_LEN);
  assign len_zero  = (code_len == '0);
  assign len_c     = CNT_W'(code_len);
  assign code_mask = ~({MAX_LEN{1'b1}} << code_len);
  assign code_ext  = ACC_W'(code_in & code_mask);

  // A padded final byte (fewer than 8 bits left) empties the accumulator.
  assign cnt_post = !xfer ? cnt_q : ((cnt_q >= CNT_BYTE) ? cnt_q - CNT_BYTE : '0);
  assign shamt    = CNT_FULL - cnt_post - len_c;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    acc_d     = xfer ? (acc_q << 8) : acc_q;
    cnt_d     = cnt_post;
    len_err_d = len_err_q;
    if (accept) begin
      if (len_bad) begin
        len_err_d = 1'b1;
      end else if (!len_zero) begin
        acc_d = acc_d | (code_ext << shamt);
        cnt_d = cnt_post + len_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q      <= RUN;
      acc_q        <= '0;
      cnt_q        <= '0;
      flush_done_q <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      len_err_q    <= len_err_d;
      flush_done_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (flush) begin
            if (cnt_d == '0) flush_done_q <= 1'b1;
            else             state_q      <= FLUSH;
          end
        end
        FLUSH: begin
          if (cnt_d == '0) begin
            state_q      <= RUN;
            flush_done_q <= 1'b1;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_deflate_bit_packer.sv
// Bench for deflate_bit_packer: directed scenarios with hand-derived bytes,
// then randomized traffic against a bit-queue model of the byte stream.
module tb_deflate_bit_packer;

  localparam int ACC_W   = 32;
  localparam int MAX_LEN = 18;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [17:0] code_in;
  logic [5:0]  code_len;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        flush_done;
  logic        len_err;

  int n_pass  = 0;
  int n_total = 0;

  deflate_bit_packer #(.ACC_W(ACC_W), .MAX_LEN(MAX_LEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .code_in    (code_in),
    .code_len   (code_len),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .flush      (flush),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .flush_done (flush_done),
    .len_err    (len_err)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [17:0] c, input logic [5:0] l,
                       input logic f, input logic r);
    in_valid  = v;
    code_in   = c;
    code_len  = l;
    flush     = f;
    out_ready = r;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #12;
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_total++; if (out_last !== 1'b0) $display("FAIL reset_out_last: got %b expected 0", out_last); else n_pass++;
    n_total++; if (flush_done !== 1'b0) $display("FAIL reset_flush_done: got %b expected 0", flush_done); else n_pass++;
    n_total++; if (len_err !== 1'b0) $display("FAIL reset_len_err: got %b expected 0", len_err); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_pack();
    drive(1'b1, 18'd1, 6'd7, 1'b0, 1'b1); tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL basic_7bits_no_byte: got %b expected 0", out_valid); else n_pass++;
    drive(1'b1, 18'd197, 6'd8, 1'b0, 1'b1); tick();
    n_total++; if (out_valid !== 1'b1) $display("FAIL basic_valid0: got %b expected 1", out_valid); else n_pass++;
    n_total++; if (out_data !== 8'h03) $display("FAIL basic_byte0: got %h expected 03", out_data); else n_pass++;
    n_total++; if (out_last !== 1'b0) $display("FAIL basic_last0: got %b expected 0", out_last); else n_pass++;
    drive(1'b0, '0, '0, 1'b1, 1'b1); tick();
    n_total++; if (out_valid !== 1'b1) $display("FAIL basic_valid1: got %b expected 1", out_valid); else n_pass++;
    n_total++; if (out_data !== 8'h8A) $display("FAIL basic_byte1: got %h expected 8a", out_data); else n_pass++;
    n_total++; if (out_last !== 1'b1) $display("FAIL basic_last1: got %b expected 1", out_last); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL basic_flush_in_ready: got %b expected 0", in_ready); else n_pass++;
    drive(1'b0, '0, '0, 1'b0, 1'b1); tick();
    n_total++; if (flush_done !== 1'b1) $display("FAIL basic_flush_done: got %b expected 1", flush_done); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL basic_empty: got %b expected 0", out_valid); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL basic_back_to_run: got %b expected 1", in_ready); else n_pass++;
    tick();
    n_total++; if (flush_done !== 1'b0) $display("FAIL basic_done_one_cycle: got %b expected 0", flush_done); else n_pass++;
  endtask

  task automatic test_byte_exact_flush();
    drive(1'b1, 18'h000A5, 6'd8, 1'b0, 1'b0); tick();
    n_total++; if (out_data !== 8'hA5) $display("FAIL exact_byte: got %h expected a5", out_data); else n_pass++;
    n_total++; if (out_last !== 1'b0) $display("FAIL exact_last_before_flush: got %b expected 0", out_last); else n_pass++;
    drive(1'b0, '0, '0, 1'b1, 1'b0); tick();
    n_total++; if (out_data !== 8'hA5) $display("FAIL exact_byte_flush: got %h expected a5", out_data); else n_pass++;
    n_total++; if (out_last !== 1'b1) $display("FAIL exact_last: got %b expected 1", out_last); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL exact_in_ready: got %b expected 0", in_ready); else n_pass++;
    drive(1'b0, '0, '0, 1'b0, 1'b1); tick();
    n_total++; if (flush_done !== 1'b1) $display("FAIL exact_flush_done: got %b expected 1", flush_done); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL exact_no_pad_byte: got %b expected 0", out_valid); else n_pass++;
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL exact_still_empty: got %b expected 0", out_valid); else n_pass++;
  endtask

  task automatic test_back_pressure();
    drive(1'b1, 18'h3FFFF, 6'd18, 1'b0, 1'b0); tick();
    n_total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready_drop: got %b expected 0", in_ready); else n_pass++;
    n_total++; if (out_data !== 8'hFF) $display("FAIL bp_byte0: got %h expected ff", out_data); else n_pass++;
    drive(1'b1, 18'h00F0F, 6'd8, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++; if (out_data !== 8'hFF) $display("FAIL bp_stall_data: got %h expected ff", out_data); else n_pass++;
      n_total++; if (out_valid !== 1'b1) $display("FAIL bp_stall_valid: got %b expected 1", out_valid); else n_pass++;
      n_total++; if (in_ready !== 1'b0) $display("FAIL bp_stall_in_ready: got %b expected 0", in_ready); else n_pass++;
    end
    drive(1'b0, '0, '0, 1'b0, 1'b1); tick();
    n_total++; if (out_data !== 8'hFF) $display("FAIL bp_byte1: got %h expected ff", out_data); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL bp_in_ready_back: got %b expected 1", in_ready); else n_pass++;
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL bp_residual_not_valid: got %b expected 0", out_valid); else n_pass++;
    drive(1'b0, '0, '0, 1'b1, 1'b1); tick();
    n_total++; if (out_data !== 8'hC0) $display("FAIL bp_pad_byte: got %h expected c0", out_data); else n_pass++;
    n_total++; if (out_last !== 1'b1) $display("FAIL bp_pad_last: got %b expected 1", out_last); else n_pass++;
    drive(1'b0, '0, '0, 1'b0, 1'b1); tick();
    n_total++; if (flush_done !== 1'b1) $display("FAIL bp_flush_done: got %b expected 1", flush_done); else n_pass++;
  endtask

  task automatic test_len_error();
    drive(1'b1, 18'h3FFFD, 6'd3, 1'b0, 1'b1); tick();
    drive(1'b1, 18'h3FFFF, 6'd20, 1'b0, 1'b1); tick();
    n_total++; if (len_err !== 1'b1) $display("FAIL lenerr_set: got %b expected 1", len_err); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL lenerr_no_byte: got %b expected 0", out_valid); else n_pass++;
    drive(1'b1, 18'h3FFFF, 6'd0, 1'b0, 1'b1); tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL len0_no_byte: got %b expected 0", out_valid); else n_pass++;
    drive(1'b1, 18'h0001F, 6'd5, 1'b0, 1'b0); tick();
    n_total++; if (out_valid !== 1'b1) $display("FAIL lenerr_cnt_unchanged: got %b expected 1", out_valid); else n_pass++;
    n_total++; if (out_data !== 8'hBF) $display("FAIL lenerr_byte: got %h expected bf", out_data); else n_pass++;
    drive(1'b0, '0, '0, 1'b0, 1'b1); tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL lenerr_drained: got %b expected 0", out_valid); else n_pass++;
    n_total++; if (len_err !== 1'b1) $display("FAIL lenerr_sticky: got %b expected 1", len_err); else n_pass++;
  endtask

  task automatic test_simultaneous();
    drive(1'b1, 18'h00ABC, 6'd12, 1'b0, 1'b0); tick();
    n_total++; if (out_data !== 8'hAB) $display("FAIL simul_byte0: got %h expected ab", out_data); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL simul_room: got %b expected 1", in_ready); else n_pass++;
    drive(1'b1, 18'h01ABC, 6'd13, 1'b0, 1'b1); tick();
    n_total++; if (out_data !== 8'hCD) $display("FAIL simul_byte1: got %h expected cd", out_data); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL simul_cnt17_full: got %b expected 0", in_ready); else n_pass++;
    drive(1'b0, '0, '0, 1'b0, 1'b1); tick();
    n_total++; if (out_data !== 8'h5E) $display("FAIL simul_byte2: got %h expected 5e", out_data); else n_pass++;
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL simul_one_bit_left: got %b expected 0", out_valid); else n_pass++;
    drive(1'b0, '0, '0, 1'b1, 1'b1); tick();
    n_total++; if (out_data !== 8'h00) $display("FAIL simul_pad_byte: got %h expected 00", out_data); else n_pass++;
    n_total++; if (out_last !== 1'b1) $display("FAIL simul_pad_last: got %b expected 1", out_last); else n_pass++;
    drive(1'b0, '0, '0, 1'b0, 1'b1); tick();
    n_total++; if (flush_done !== 1'b1) $display("FAIL simul_flush_done: got %b expected 1", flush_done); else n_pass++;
  endtask

  task automatic test_reset_mid_stream();
    drive(1'b1, 18'h00015, 6'd5, 1'b0, 1'b0); tick();
    drive(1'b0, '0, '0, 1'b1, 1'b0); tick();
    n_total++; if (out_data !== 8'hA8) $display("FAIL rst_mid_pending: got %h expected a8", out_data); else n_pass++;
    n_total++; if (out_last !== 1'b1) $display("FAIL rst_mid_in_flush: got %b expected 1", out_last); else n_pass++;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL rst_mid_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL rst_mid_run: got %b expected 1", in_ready); else n_pass++;
    n_total++; if (len_err !== 1'b0) $display("FAIL rst_mid_len_err: got %b expected 0", len_err); else n_pass++;
    n_total++; if (out_last !== 1'b0) $display("FAIL rst_mid_out_last: got %b expected 0", out_last); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 18'h00001, 6'd1, 1'b0, 1'b0); tick();
    drive(1'b1, 18'h00000, 6'd7, 1'b0, 1'b0); tick();
    n_total++; if (out_data !== 8'h80) $display("FAIL rst_mid_fresh_byte: got %h expected 80", out_data); else n_pass++;
    n_total++; if (out_last !== 1'b0) $display("FAIL rst_mid_fresh_last: got %b expected 0", out_last); else n_pass++;
    drive(1'b0, '0, '0, 1'b0, 1'b1); tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL rst_mid_drained: got %b expected 0", out_valid); else n_pass++;
  endtask

  // Model: the pending stream is a queue of bits, oldest first.
  task automatic test_random();
    bit          mq[$];
    bit          m_fl   = 1'b0;
    bit          m_err  = 1'b0;
    bit          m_done = 1'b0;
    int          sz;
    logic        e_rdy, e_val, e_last;
    logic [7:0]  e_data;
    logic        v, f, r;
    logic [17:0] c;
    logic [5:0]  l;
    int          pick;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      sz     = mq.size();
      e_rdy  = !m_fl && (sz <= ACC_W - MAX_LEN);
      e_val  = (sz >= 8) || (m_fl && sz > 0);
      e_last = m_fl && (sz > 0) && (sz <= 8);
      e_data = '0;
      for (int i = 0; i < 8; i++) if (i < sz) e_data[7-i] = mq[i];
      n_total++; if (in_ready !== e_rdy) $display("FAIL rand_in_ready cyc %0d: got %b expected %b", cyc, in_ready, e_rdy); else n_pass++;
      n_total++; if (out_valid !== e_val) $display("FAIL rand_out_valid cyc %0d: got %b expected %b", cyc, out_valid, e_val); else n_pass++;
      n_total++; if (out_last !== e_last) $display("FAIL rand_out_last cyc %0d: got %b expected %b", cyc, out_last, e_last); else n_pass++;
      n_total++; if (flush_done !== m_done) $display("FAIL rand_flush_done cyc %0d: got %b expected %b", cyc, flush_done, m_done); else n_pass++;
      n_total++; if (len_err !== m_err) $display("FAIL rand_len_err cyc %0d: got %b expected %b", cyc, len_err, m_err); else n_pass++;
      if (e_val) begin
        n_total++; if (out_data !== e_data) $display("FAIL rand_out_data cyc %0d: got %h expected %h", cyc, out_data, e_data); else n_pass++;
      end

      v    = ($urandom_range(0, 9) < 7);
      c    = 18'($urandom);
      pick = int'($urandom_range(0, 99));
      if (pick < 5)       l = 6'($urandom_range(19, 63));
      else if (pick < 10) l = 6'd0;
      else                l = 6'($urandom_range(1, 18));
      f    = ($urandom_range(0, 19) == 0);
      r    = ($urandom_range(0, 3) != 0);
      drive(v, c, l, f, r);

      m_done = 1'b0;
      if (e_val && r) begin
        for (int i = 0; i < 8; i++) if (mq.size() > 0) void'(mq.pop_front());
      end
      if (v && e_rdy) begin
        if (int'(l) > MAX_LEN) m_err = 1'b1;
        else for (int i = int'(l) - 1; i >= 0; i--) mq.push_back(c[i]);
      end
      if (!m_fl) begin
        if (f) begin
          if (mq.size() == 0) m_done = 1'b1;
          else                m_fl   = 1'b1;
        end
      end else if (mq.size() == 0) begin
        m_fl   = 1'b0;
        m_done = 1'b1;
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic_pack();
    test_byte_exact_flush();
    test_back_pressure();
    test_len_error();
    test_simultaneous();
    test_reset_mid_stream();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/deflate_bit_packer.md
# deflate_bit_packer

Serialises variable-length codewords into a byte stream. It sits directly downstream of the length encoder in the compression path and consumes its `{encoded_length, valid_bits}` pair. Accepted bits are held in an accumulator, and full bytes are emitted over a valid/ready handshake. A flush request pads the final partial byte with zeros and marks the end of the stream.

## Interface

**Parameters**
- `ACC_W`, default 32: accumulator width in bits. Must be ≥ 26.
- `MAX_LEN`, default 18: maximum legal codeword length, equal to the encoder output width.

**Ports**
- `clk`  in  1: the single clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `code_in`  in  18: codeword value. Only bits `[code_len-1:0]` are used; higher bits are ignored and masked.
- `code_len`  in  6: number of valid bits, 0..`MAX_LEN`.
- `in_valid`  in  1: codeword present on `code_in`/`code_len`.
- `in_ready`  out  1: the packer can accept a codeword this cycle.
- `flush`  in  1: end-of-stream request. Sampled only in RUN.
- `out_data`  out  8: output byte.
- `out_valid`  out  1: `out_data` is valid.
- `out_ready`  in  1: downstream accepts the byte.
- `out_last`  out  1: current byte is the final byte of the flushed stream.
- `flush_done`  out  1: one-cycle pulse when a flush completes.
- `len_err`  out  1: sticky flag, set when a codeword with `code_len > MAX_LEN` is accepted.

## Operation

**Bit order**
- Codeword bits are emitted MSB-first: `code_in[code_len-1]` first, `code_in[0]` last.
- Bytes are filled MSB-first, so the first emitted bit lands in `out_data[7]`.

**Accumulator**
- `acc[ACC_W-1:0]` is left-aligned.
- `cnt` (0..`ACC_W`) holds the number of valid bits, which occupy `acc[ACC_W-1 : ACC_W-cnt]`.

**Handshakes**
- Input accept: `in_valid && in_ready`.
- Output transfer: `out_valid && out_ready`.

**Control outputs**
- `in_ready = (state == RUN) && (cnt <= ACC_W - MAX_LEN)`.
- `out_data = acc[ACC_W-1 : ACC_W-8]`.
- `out_valid = (cnt >= 8) || (state == FLUSH && cnt > 0)`.

**Update order within one cycle**
1. If a transfer occurs: shift `acc` left by 8 and `cnt -= 8`. For a padded final byte, `cnt` goes to 0.
2. If an accept occurs: OR the masked codeword into `acc` at bit position `ACC_W - cnt' - code_len`, where `cnt'` is the post-transfer count, then `cnt = cnt' + code_len`.

**Length rules**
- `code_len == 0`: accepted with no effect. This matches the encoder's disabled or out-of-range output.
- `code_len > MAX_LEN`: accepted and discarded; `len_err` is set and `cnt` is unchanged.

**State machine (RUN, FLUSH)**
- RUN → FLUSH when `flush == 1`. Any codeword accepted in the same cycle is packed before the flush takes effect.
- FLUSH: `in_ready = 0`. Full bytes drain normally.
  - If the residual is 1..7 bits, it is emitted zero-padded with `out_last = 1`.
  - If `cnt == 8` exactly, that full byte carries `out_last = 1`.
- FLUSH → RUN in the cycle after the last transfer, or immediately if `cnt == 0` on entry. `flush_done` pulses for one cycle on that return.
- A flush with an empty buffer emits no byte and still pulses `flush_done`.
- `flush` asserted while already in FLUSH is ignored.

## Timing

- **Reset** (asynchronous, active-low):
  - Reset values: `acc = 0`, `cnt = 0`, `state = RUN`, `out_valid = 0`, `out_last = 0`, `flush_done = 0`, `len_err = 0`.
  - `in_ready` reads 1 while in reset.
  - Reset asserted mid-stream discards all buffered bits; no partial byte is emitted.
- **Latency:** a codeword accepted in cycle t makes its bits visible on `out_data` from cycle t+1 at the earliest.
- **Throughput:** one codeword in and one byte out per cycle, simultaneously.
- **Stall:** while `out_valid && !out_ready`, `out_data` and `out_last` must stay stable. Accepts are still allowed while space remains; they only append below the current byte.
- **Combinational paths:** all outputs derive from registers only. There is no path from `in_valid`, `out_ready` or `flush` to any output.
- **Overflow:** impossible. The guard `cnt ≤ ACC_W - MAX_LEN` plus at most `MAX_LEN` new bits gives `cnt ≤ ACC_W`.

## Test plan

- **Basic pack:** accept (code 1, len 7), then (197, len 8), then `flush`, with `out_ready = 1` → bytes 0x03, then 0x8A with `out_last = 1`; `flush_done` pulses once; `cnt = 0`.
- **Byte-exact flush:** accept (0xA5, len 8), then `flush` → single byte 0xA5 with `out_last = 1`; no padded byte follows.
- **Back-pressure:** `out_ready = 0`; accept (0x3FFFF, len 18) → `in_ready` drops (`cnt` 18 > 14). Release `out_ready` → 0xFF, 0xFF, then flush gives 0xC0 last. `out_data` is held stable throughout the stall.
- **Length error:** accept `code_len = 20` → `len_err` is set and sticky, `cnt` unchanged, no byte emitted. A `code_len = 0` accept → no change at all.
- **Simultaneous events:** with `cnt = 12`, a byte transfer and a len-13 accept in the same cycle → `cnt = 17`; the new bits land directly after the residual 4 bits.
- **Reset mid-stream:** pulse `rst_n` low with `cnt = 5` and `state = FLUSH` → `out_valid = 0`, `state = RUN`, `len_err = 0`; the next stream packs from bit 7 of a fresh byte.
